// File: rtl/noc_vc_buffer.sv
// noc_vc_buffer: CHANNELS independent flit queues behind one shared input bus, optional full-packet gating.
// Define NOC_VC_BUFFER_PKTSIZE_EN (with FULLPACKET=1) to build the per-VC packet_size reporting.
module noc_vc_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8,
  parameter int FULLPACKET = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FLIT_WIDTH-1:0]          in_flit,
  input  logic                           in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
  output logic [CHANNELS-1:0]            out_last,
  output logic [CHANNELS-1:0]            out_valid,
  input  logic [CHANNELS-1:0]            out_ready,
  output logic [CHANNELS*(AW+1)-1:0]     packet_size,
  output logic [CHANNELS-1:0]            pkt_overflow
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [PW-1:0] PTR_WRAP = PW'(DEPTH - 2);

  // Multiple VCs selected at once is a protocol error: nothing gets written.
  logic legal;
  assign legal = $onehot0(in_valid);

  a_one_vc: assert property (@(posedge clk) disable iff (rst) $onehot0(in_valid));

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    logic [AW:0]           fill;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [FLIT_WIDTH:0]   ram [DEPTH-1];
    logic [FLIT_WIDTH-1:0] head_flit;
    logic                  head_last;
    logic                  valid;
    logic                  ready;
    logic                  wr;
    logic                  rd;
    logic                  through;
    logic                  ram_wr;
    logic                  ram_rd;
    logic                  ovf;
    logic [AW:0]           size;

    assign ready   = (fill < FILL_MAX) & ~rst;
    assign wr      = in_valid[v] & ready & legal;
    assign rd      = valid & out_ready[v];
    assign through = (fill == '0) | ((fill == FILL_ONE) & rd);
    assign ram_wr  = wr & ~through;
    assign ram_rd  = rd & (fill > FILL_ONE);

    always_ff @(posedge clk) begin
      if (ram_wr) ram[wptr] <= {in_last, in_flit};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fill      <= '0;
        wptr      <= '0;
        rptr      <= '0;
        head_flit <= '0;
        head_last <= 1'b0;
      end else begin
        if (wr & through) begin
          head_flit <= in_flit;
          head_last <= in_last;
        end else if (ram_rd) begin
          {head_last, head_flit} <= ram[rptr];
        end
        if (ram_wr) wptr <= (wptr == PTR_WRAP) ? '0 : wptr + 1'b1;
        if (ram_rd) rptr <= (rptr == PTR_WRAP) ? '0 : rptr + 1'b1;
        if (wr & ~rd)      fill <= fill + 1'b1;
        else if (rd & ~wr) fill <= fill - 1'b1;
      end
    end

    if (FULLPACKET != 0) begin : g_fp
      logic [AW:0] pkt_cnt;
      logic        bypass;
      logic        inc;
      logic        dec;

      assign inc   = wr & in_last;
      assign dec   = rd & head_last;
      assign valid = (fill != '0) & ((pkt_cnt != '0) | bypass);

      // A full VC with no complete packet can never finish: forward it cut-through.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pkt_cnt <= '0;
          bypass  <= 1'b0;
          ovf     <= 1'b0;
        end else begin
          if (inc & ~dec)      pkt_cnt <= pkt_cnt + 1'b1;
          else if (dec & ~inc) pkt_cnt <= pkt_cnt - 1'b1;
          if (dec) begin
            bypass <= 1'b0;
          end else if ((fill == FILL_MAX) && (pkt_cnt == '0)) begin
            bypass <= 1'b1;
            ovf    <= 1'b1;
          end
        end
      end

`ifdef NOC_VC_BUFFER_PKTSIZE_EN
      logic [AW:0]   size_q [DEPTH];
      logic [AW-1:0] sq_wptr;
      logic [AW-1:0] sq_rptr;
      logic [AW:0]   in_cnt;
      logic [AW:0]   rd_cnt;

      always_ff @(posedge clk) begin
        if (inc) size_q[sq_wptr] <= in_cnt + 1'b1;
      end

      // Overflowed packets also get a queue entry so later sizes stay aligned.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sq_wptr <= '0;
          sq_rptr <= '0;
          in_cnt  <= '0;
          rd_cnt  <= '0;
        end else begin
          if (wr)  in_cnt  <= in_last ? '0 : in_cnt + 1'b1;
          if (inc) sq_wptr <= sq_wptr + 1'b1;
          if (rd)  rd_cnt  <= head_last ? '0 : rd_cnt + 1'b1;
          if (dec) sq_rptr <= sq_rptr + 1'b1;
        end
      end

      assign size = (valid & ~bypass) ? size_q[sq_rptr] - rd_cnt : '0;
`else
      assign size = '0;
`endif
    end else begin : g_nofp
      assign valid = (fill != '0);
      assign ovf   = 1'b0;
      assign size  = '0;
    end

    assign in_ready[v]                             = ready;
    assign out_flit[v*FLIT_WIDTH +: FLIT_WIDTH]    = head_flit;
    assign out_last[v]                             = head_last;
    assign out_valid[v]                            = valid;
    assign packet_size[v*(AW+1) +: AW+1]           = size;
    assign pkt_overflow[v]                         = ovf;
  end

endmodule

// File: tb/tb_noc_vc_buffer.sv
// Scoreboard bench for noc_vc_buffer: d0 FULLPACKET=0/DEPTH=8, d1 FULLPACKET=1/DEPTH=8, d2 FULLPACKET=1/DEPTH=4.
module tb_noc_vc_buffer;
  localparam int FW = 32;

`ifdef NOC_VC_BUFFER_PKTSIZE_EN
  localparam bit PS_ON = 1'b1;
`else
  localparam bit PS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0]   d0_in_flit, d1_in_flit, d2_in_flit;
  logic            d0_in_last, d1_in_last, d2_in_last;
  logic [1:0]      d0_in_valid, d1_in_valid, d2_in_valid;
  logic [1:0]      d0_in_ready, d1_in_ready, d2_in_ready;
  logic [2*FW-1:0] d0_out_flit, d1_out_flit, d2_out_flit;
  logic [1:0]      d0_out_last, d1_out_last, d2_out_last;
  logic [1:0]      d0_out_valid, d1_out_valid, d2_out_valid;
  logic [1:0]      d0_out_ready, d1_out_ready, d2_out_ready;
  logic [7:0]      d0_packet_size, d1_packet_size;
  logic [5:0]      d2_packet_size;
  logic [1:0]      d0_pkt_overflow, d1_pkt_overflow, d2_pkt_overflow;

  logic [FW:0] q0[$];
  logic [FW:0] q0b[$];
  logic [FW:0] q1[$];
  logic [FW:0] q2[$];
  logic [FW:0] exp_h;

  noc_vc_buffer #(.FLIT_WIDTH(FW), .CHANNELS(2), .DEPTH(8), .FULLPACKET(0)) u_d0 (
    .clk(clk), .rst(rst), .in_flit(d0_in_flit), .in_last(d0_in_last), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .out_flit(d0_out_flit), .out_last(d0_out_last), .out_valid(d0_out_valid),
    .out_ready(d0_out_ready), .packet_size(d0_packet_size), .pkt_overflow(d0_pkt_overflow));

  noc_vc_buffer #(.FLIT_WIDTH(FW), .CHANNELS(2), .DEPTH(8), .FULLPACKET(1)) u_d1 (
    .clk(clk), .rst(rst), .in_flit(d1_in_flit), .in_last(d1_in_last), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .out_flit(d1_out_flit), .out_last(d1_out_last), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .packet_size(d1_packet_size), .pkt_overflow(d1_pkt_overflow));

  noc_vc_buffer #(.FLIT_WIDTH(FW), .CHANNELS(2), .DEPTH(4), .FULLPACKET(1)) u_d2 (
    .clk(clk), .rst(rst), .in_flit(d2_in_flit), .in_last(d2_in_last), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .out_flit(d2_out_flit), .out_last(d2_out_last), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .packet_size(d2_packet_size), .pkt_overflow(d2_pkt_overflow));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    total++; if (d0_in_ready !== 2'b00 || d1_in_ready !== 2'b00 || d2_in_ready !== 2'b00) begin
      bad++; $display("FAIL rst_in_ready: got %b %b %b want 00", d0_in_ready, d1_in_ready, d2_in_ready); end
    total++; if ({d0_out_valid, d1_out_valid, d2_out_valid} !== 6'b0) begin
      bad++; $display("FAIL rst_out_valid: got %b want 0", {d0_out_valid, d1_out_valid, d2_out_valid}); end
    total++; if (d0_out_flit !== '0 || d0_out_last !== 2'b00) begin
      bad++; $display("FAIL rst_out_flit: got %h/%b want 0", d0_out_flit, d0_out_last); end
    total++; if (d1_packet_size !== 8'd0 || {d0_pkt_overflow, d1_pkt_overflow, d2_pkt_overflow} !== 6'b0) begin
      bad++; $display("FAIL rst_size_ovf: got %h/%b want 0", d1_packet_size, {d0_pkt_overflow, d1_pkt_overflow, d2_pkt_overflow}); end
    rst = 1'b0;
    #1;
    total++; if (d0_in_ready !== 2'b11 || d1_in_ready !== 2'b11 || d2_in_ready !== 2'b11) begin
      bad++; $display("FAIL post_rst_ready: got %b %b %b want 11", d0_in_ready, d1_in_ready, d2_in_ready); end
    tick;
  endtask

  task automatic test_fill_drain;
    d0_out_ready = 2'b00;
    for (int i = 0; i < 8; i++) begin
      d0_in_valid = 2'b01; d0_in_flit = 32'h1000 + i; d0_in_last = (i == 7);
      q0.push_back({d0_in_last, d0_in_flit});
      tick;
      total++; if (d0_in_ready[0] !== (i < 7)) begin
        bad++; $display("FAIL fill_ready0 i=%0d: got %b want %b", i, d0_in_ready[0], (i < 7)); end
      total++; if (d0_in_ready[1] !== 1'b1) begin
        bad++; $display("FAIL fill_ready1 i=%0d: got %b want 1", i, d0_in_ready[1]); end
    end
    d0_in_valid = 2'b00; d0_in_last = 1'b0;
    d0_out_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      exp_h = q0.pop_front();
      total++; if ({d0_out_valid[0], d0_out_last[0], d0_out_flit[FW-1:0]} !== {1'b1, exp_h}) begin
        bad++; $display("FAIL drain_head i=%0d: got v=%b l=%b %h want v=1 l=%b %h", i, d0_out_valid[0],
                        d0_out_last[0], d0_out_flit[FW-1:0], exp_h[FW], exp_h[FW-1:0]); end
      tick;
    end
    d0_out_ready = 2'b00;
    total++; if (d0_out_valid[0] !== 1'b0) begin
      bad++; $display("FAIL drain_empty: got %b want 0", d0_out_valid[0]); end
  endtask

  task automatic test_latency;
    d0_in_valid = 2'b10; d0_in_flit = 32'hA5; d0_in_last = 1'b1;
    q0b.push_back({d0_in_last, d0_in_flit});
    total++; if (d0_out_valid[1] !== 1'b0) begin
      bad++; $display("FAIL lat_pre: got %b want 0", d0_out_valid[1]); end
    tick;
    d0_in_valid = 2'b00; d0_in_last = 1'b0;
    exp_h = q0b.pop_front();
    total++; if ({d0_out_valid[1], d0_out_last[1], d0_out_flit[2*FW-1:FW]} !== {1'b1, exp_h}) begin
      bad++; $display("FAIL lat_head: got v=%b %h want v=1 %h", d0_out_valid[1], d0_out_flit[2*FW-1:FW], exp_h[FW-1:0]); end
    d0_out_ready = 2'b10;
    tick;
    d0_out_ready = 2'b00;
    total++; if (d0_out_valid[1] !== 1'b0) begin
      bad++; $display("FAIL lat_drain: got %b want 0", d0_out_valid[1]); end
  endtask

  task automatic test_full_read_write;
    d0_out_ready = 2'b00;
    for (int i = 0; i < 8; i++) begin
      d0_in_valid = 2'b01; d0_in_flit = 32'h2000 + i; d0_in_last = (i == 7);
      q0.push_back({d0_in_last, d0_in_flit});
      tick;
    end
    d0_in_valid = 2'b01; d0_in_flit = 32'hDEAD; d0_in_last = 1'b0;
    d0_out_ready = 2'b01;
    total++; if (d0_in_ready[0] !== 1'b0) begin
      bad++; $display("FAIL full_refuse: got %b want 0", d0_in_ready[0]); end
    exp_h = q0.pop_front();
    total++; if ({d0_out_last[0], d0_out_flit[FW-1:0]} !== exp_h) begin
      bad++; $display("FAIL full_head: got %h want %h", d0_out_flit[FW-1:0], exp_h[FW-1:0]); end
    tick;
    d0_in_valid = 2'b00;
    total++; if (d0_in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL full_fill7: got %b want 1", d0_in_ready[0]); end
    for (int i = 0; i < 7; i++) begin
      exp_h = q0.pop_front();
      total++; if ({d0_out_valid[0], d0_out_last[0], d0_out_flit[FW-1:0]} !== {1'b1, exp_h}) begin
        bad++; $display("FAIL full_drain i=%0d: got v=%b %h want v=1 %h", i, d0_out_valid[0], d0_out_flit[FW-1:0], exp_h[FW-1:0]); end
      tick;
    end
    d0_out_ready = 2'b00;
    total++; if (d0_out_valid[0] !== 1'b0) begin
      bad++; $display("FAIL full_extra: got v=%b %h want v=0", d0_out_valid[0], d0_out_flit[FW-1:0]); end
  endtask

  task automatic test_fullpacket;
    d1_out_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      total++; if (d1_out_valid[0] !== 1'b0) begin
        bad++; $display("FAIL fp_gated i=%0d: got %b want 0", i, d1_out_valid[0]); end
      d1_in_valid = 2'b01; d1_in_flit = 32'h3000 + i; d1_in_last = (i == 2);
      q1.push_back({d1_in_last, d1_in_flit});
      tick;
    end
    d1_in_valid = 2'b00; d1_in_last = 1'b0;
    total++; if (d1_out_valid[0] !== 1'b1) begin
      bad++; $display("FAIL fp_valid: got %b want 1", d1_out_valid[0]); end
    d1_out_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_h = q1.pop_front();
      total++; if ({d1_out_valid[0], d1_out_last[0], d1_out_flit[FW-1:0]} !== {1'b1, exp_h}) begin
        bad++; $display("FAIL fp_head i=%0d: got v=%b %h want %h", i, d1_out_valid[0], d1_out_flit[FW-1:0], exp_h[FW-1:0]); end
      total++; if (d1_packet_size[3:0] !== (PS_ON ? 4'(3 - i) : 4'd0)) begin
        bad++; $display("FAIL fp_size i=%0d: got %0d want %0d", i, d1_packet_size[3:0], (PS_ON ? 3 - i : 0)); end
      tick;
    end
    d1_out_ready = 2'b00;
    total++; if (d1_out_valid[0] !== 1'b0 || d1_packet_size[3:0] !== 4'd0) begin
      bad++; $display("FAIL fp_done: got v=%b size=%0d want 0/0", d1_out_valid[0], d1_packet_size[3:0]); end
  endtask

  task automatic test_overflow;
    int sent, got, cyc;
    d2_out_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      total++; if (d2_out_valid[0] !== 1'b0) begin
        bad++; $display("FAIL ovf_gated i=%0d: got %b want 0", i, d2_out_valid[0]); end
      d2_in_valid = 2'b01; d2_in_flit = 32'h4000 + i; d2_in_last = 1'b0;
      q2.push_back({d2_in_last, d2_in_flit});
      tick;
    end
    d2_in_valid = 2'b00;
    total++; if ({d2_in_ready[0], d2_pkt_overflow[0], d2_out_valid[0]} !== 3'b000) begin
      bad++; $display("FAIL ovf_full: got rdy/ovf/v=%b%b%b want 000", d2_in_ready[0], d2_pkt_overflow[0], d2_out_valid[0]); end
    tick;
    total++; if ({d2_pkt_overflow[0], d2_out_valid[0]} !== 2'b11) begin
      bad++; $display("FAIL ovf_flag: got ovf/v=%b%b want 11", d2_pkt_overflow[0], d2_out_valid[0]); end
    d2_out_ready = 2'b01;
    sent = 4; got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      if (d2_out_valid[0]) begin
        total++;
        if (q2.size() == 0) begin
          bad++; $display("FAIL ovf_extra: got %h want nothing", d2_out_flit[FW-1:0]);
        end else begin
          exp_h = q2.pop_front();
          if ({d2_out_last[0], d2_out_flit[FW-1:0], d2_packet_size[2:0]} !== {exp_h, 3'd0}) begin
            bad++; $display("FAIL ovf_drain n=%0d: got l=%b %h size=%0d want l=%b %h size=0", got, d2_out_last[0],
                            d2_out_flit[FW-1:0], d2_packet_size[2:0], exp_h[FW], exp_h[FW-1:0]); end
        end
        got++;
      end
      if (sent < 6 && d2_in_ready[0]) begin
        d2_in_valid = 2'b01; d2_in_flit = 32'h4000 + sent; d2_in_last = (sent == 5);
        q2.push_back({d2_in_last, d2_in_flit});
        sent++;
      end else begin
        d2_in_valid = 2'b00;
      end
      tick;
      cyc++;
    end
    d2_in_valid = 2'b00; d2_in_last = 1'b0;
    total++; if (got !== 6) begin
      bad++; $display("FAIL ovf_timeout: got %0d flits want 6", got); end
    total++; if ({d2_out_valid[0], d2_pkt_overflow[0]} !== 2'b01) begin
      bad++; $display("FAIL ovf_sticky: got v/ovf=%b%b want 01", d2_out_valid[0], d2_pkt_overflow[0]); end
    d2_in_valid = 2'b01; d2_in_flit = 32'h5000; d2_in_last = 1'b0;
    q2.push_back({d2_in_last, d2_in_flit});
    tick;
    total++; if (d2_out_valid[0] !== 1'b0) begin
      bad++; $display("FAIL ovf_regate: got %b want 0", d2_out_valid[0]); end
    d2_in_flit = 32'h5001; d2_in_last = 1'b1;
    q2.push_back({d2_in_last, d2_in_flit});
    tick;
    d2_in_valid = 2'b00; d2_in_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_h = q2.pop_front();
      total++; if ({d2_out_valid[0], d2_out_last[0], d2_out_flit[FW-1:0]} !== {1'b1, exp_h}) begin
        bad++; $display("FAIL pkt2_head i=%0d: got v=%b %h want %h", i, d2_out_valid[0], d2_out_flit[FW-1:0], exp_h[FW-1:0]); end
      total++; if (d2_packet_size[2:0] !== (PS_ON ? 3'(2 - i) : 3'd0)) begin
        bad++; $display("FAIL pkt2_size i=%0d: got %0d want %0d", i, d2_packet_size[2:0], (PS_ON ? 2 - i : 0)); end
      tick;
    end
    d2_out_ready = 2'b00;
    total++; if (d2_out_valid[0] !== 1'b0) begin
      bad++; $display("FAIL pkt2_done: got %b want 0", d2_out_valid[0]); end
  endtask

  task automatic test_reset_mid;
    d0_out_ready = 2'b00; d1_out_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      d0_in_valid = 2'b01; d0_in_flit = 32'h6000 + i; d0_in_last = 1'b0;
      d1_in_valid = 2'b01; d1_in_flit = 32'h7000 + i; d1_in_last = 1'b0;
      tick;
    end
    d0_in_valid = 2'b00; d1_in_valid = 2'b00;
    total++; if ({d0_out_valid[0], d0_out_flit[FW-1:0]} !== {1'b1, 32'h6000}) begin
      bad++; $display("FAIL mid_pre: got v=%b %h want v=1 6000", d0_out_valid[0], d0_out_flit[FW-1:0]); end
    rst = 1'b1;
    #1;
    total++; if (d0_out_valid !== 2'b00 || d0_out_flit !== '0 || d0_out_last !== 2'b00 || d0_in_ready !== 2'b00) begin
      bad++; $display("FAIL mid_rst_d0: got v=%b %h l=%b r=%b want 0", d0_out_valid, d0_out_flit, d0_out_last, d0_in_ready); end
    total++; if (d1_out_valid !== 2'b00 || d1_out_flit !== '0 || d1_packet_size !== 8'd0 || d2_pkt_overflow !== 2'b00) begin
      bad++; $display("FAIL mid_rst_d1d2: got v=%b %h size=%h ovf=%b want 0", d1_out_valid, d1_out_flit, d1_packet_size, d2_pkt_overflow); end
    tick;
    tick;
    rst = 1'b0;
    d1_in_valid = 2'b01; d1_in_flit = 32'h8000; d1_in_last = 1'b1;
    q1.push_back({d1_in_last, d1_in_flit});
    tick;
    d1_in_valid = 2'b00; d1_in_last = 1'b0;
    exp_h = q1.pop_front();
    total++; if ({d1_out_valid[0], d1_out_last[0], d1_out_flit[FW-1:0]} !== {1'b1, exp_h}) begin
      bad++; $display("FAIL mid_new: got v=%b %h want v=1 %h", d1_out_valid[0], d1_out_flit[FW-1:0], exp_h[FW-1:0]); end
    total++; if (d1_packet_size[3:0] !== (PS_ON ? 4'd1 : 4'd0)) begin
      bad++; $display("FAIL mid_size: got %0d want %0d", d1_packet_size[3:0], (PS_ON ? 1 : 0)); end
    d1_out_ready = 2'b01;
    tick;
    d1_out_ready = 2'b00;
    total++; if (d1_out_valid[0] !== 1'b0 || d0_out_valid !== 2'b00) begin
      bad++; $display("FAIL mid_after: got d1v=%b d0v=%b want 0", d1_out_valid[0], d0_out_valid); end
  endtask

  initial begin
    d0_in_flit = '0; d0_in_last = 1'b0; d0_in_valid = 2'b00; d0_out_ready = 2'b00;
    d1_in_flit = '0; d1_in_last = 1'b0; d1_in_valid = 2'b00; d1_out_ready = 2'b00;
    d2_in_flit = '0; d2_in_last = 1'b0; d2_in_valid = 2'b00; d2_out_ready = 2'b00;
    test_reset;
    test_fill_drain;
    test_latency;
    test_full_read_write;
    test_fullpacket;
    test_overflow;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noc_vc_buffer.md
# noc_vc_buffer

Multi-virtual-channel packet buffer for NoC router input ports and network adapters. It generalises the single-channel NoC FIFO to `CHANNELS` independent per-VC queues behind one shared input flit bus, with a 1-cycle minimum in-to-out latency. An optional full-packet mode signals a valid flit only once a complete packet is stored. The block detects packets too long to ever complete, flags them and forwards them cut-through instead of deadlocking.

## Interface
- `FLIT_WIDTH`, 32, flit payload width
- `CHANNELS`, 2, number of virtual channels, ≥1
- `DEPTH`, 8, flit capacity per VC including the output register; power of two, ≥2
- `FULLPACKET`, 0, 1 = per-VC `out_valid` gated on a complete stored packet
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_flit`  in  FLIT_WIDTH  shared input flit
- `in_last`  in  1  last flit of packet
- `in_valid`  in  CHANNELS  per-VC valid; at most one bit set per cycle
- `in_ready`  out  CHANNELS  per-VC ready
- `out_flit`  out  CHANNELS*FLIT_WIDTH  per-VC head flit; VC v at `[v*FLIT_WIDTH +: FLIT_WIDTH]`
- `out_last`  out  CHANNELS  per-VC head last flag
- `out_valid`  out  CHANNELS  per-VC valid
- `out_ready`  in  CHANNELS  per-VC ready
- `packet_size`  out  CHANNELS*(AW+1)  per-VC remaining flits of the head packet, AW=$clog2(DEPTH)
- `pkt_overflow`  out  CHANNELS  sticky per-VC error flag

## Operation
- Per VC: `fill[v]` (AW+1 bits, 0..DEPTH), LUT-RAM storage of DEPTH-1 entries, plus an output register.
- `in_ready[v] = (fill[v] < DEPTH) & ~rst`. `in_ready` does not depend on `out_ready`: a full VC refuses writes even when it is read in the same cycle.
- Write when `in_valid[v] & in_ready[v]`. Read when `out_valid[v] & out_ready[v]`.
- Write-through: if `fill==0`, or `fill==1` with a read, the input goes straight to the output register. Otherwise it goes to RAM, and a read refills the output register from RAM.
- Simultaneous write and read leaves `fill` unchanged. RAM pointers wrap modulo DEPTH-1.
- More than one `in_valid` bit set is illegal; it is caught by a simulation assertion and no flit is written.
- FULLPACKET=0: `out_valid[v] = fill[v] > 0`.
- FULLPACKET=1: `pkt_cnt[v]` (AW+1 bits) counts +1 on a write with `in_last` and −1 on a read with `out_last`; both at once leaves it unchanged. `out_valid[v] = (pkt_cnt[v] > 0) | bypass[v]`, and additionally requires `fill[v] > 0`.
- Overflow: if `fill==DEPTH` and `pkt_cnt==0`, set `pkt_overflow[v]` (cleared only by reset) and `bypass[v]`. `bypass[v]` clears on the read of a flit with `out_last`.

## Timing
- Reset values: `fill`, `pkt_cnt`, pointers, `bypass`, `pkt_overflow`, `out_valid`, `out_flit`, `out_last` and `packet_size` are all 0. `in_ready` is 0 while `rst` is high.
- Latency: a flit written into an empty VC at edge N is valid after edge N (FULLPACKET=0).
- FULLPACKET=1: `out_valid` rises the cycle after the last flit is written.
- `pkt_overflow` and `bypass` assert the cycle after `fill` reaches DEPTH; `out_valid` rises in that same cycle.
- Reset asserted mid-packet drops all stored flits at once, with no partial output.

## Configuration
- `NOC_VC_BUFFER_PKTSIZE_EN` defined, with FULLPACKET=1:
  - A per-VC size queue of DEPTH entries records each packet's flit count at its last-flit write.
  - `packet_size[v]` shows the head packet's full size when it becomes valid and decrements on each read.
  - `packet_size[v]` is 0 in bypass and when not valid.
- Macro undefined, or FULLPACKET=0: size logic is not compiled and `packet_size` is tied to 0.

## Test plan
- FULLPACKET=0, DEPTH=8: write 8 flits on VC0 with `out_ready=0` -> `in_ready[0]` falls after the 8th write and VC1 stays ready. Then read all 8 -> data in order, `out_last` only on the 8th.
- Empty VC1: write one flit 0xA5 at edge N -> `out_valid[1]=1` after N and `out_flit[1]=0xA5`.
- FULLPACKET=1: write a 3-flit packet on VC0 -> `out_valid[0]` stays 0 until the cycle after the last flit, then `packet_size=3,2,1` on successive reads (macro on).
- FULLPACKET=1, DEPTH=4: write a 6-flit packet -> `pkt_overflow[0]=1` after 4 flits, all 6 flits drain in order, then bypass clears and a following 2-flit packet is gated normally.
- Full VC with `out_ready=1` and `in_valid` high -> the read proceeds, `fill` drops to 7 and the write is refused that cycle.
- Assert `rst` mid-packet with 5 flits stored -> all outputs 0 at once; after deassertion, a new 1-flit packet passes with `packet_size=1`.
